// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller.
// Opcodes, op classes, FSM states, forwarding selects.
package pipeline_pkg;

  localparam int OP_W = 6;
  localparam int RA_W = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 6'b000000;
  localparam logic [OP_W-1:0] OP_LOAD  = 6'b010100;
  localparam logic [OP_W-1:0] OP_STORE = 6'b010101;
  localparam logic [OP_W-1:0] OP_JUMP  = 6'b011110;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b010001;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_JUMP,
    CLS_HALT
  } op_cls_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_JWAIT,
    ST_HALT
  } state_e;

  typedef enum logic {
    DST_RD,
    DST_RT
  } dst_sel_e;

  typedef struct packed {
    op_cls_e  cls;
    logic     reads_a;
    logic     reads_b;
    logic     writes;
    dst_sel_e dst_sel;
  } op_info_t;

  typedef struct packed {
    logic            valid;
    logic            is_load;
    logic [RA_W-1:0] dst;
    logic [RA_W-1:0] src_a;
    logic [RA_W-1:0] src_b;
  } sb_entry_t;

  // MEM result is younger than WB, so it wins a tie.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input sb_entry_t       mem,
    input sb_entry_t       wb
  );
    if (src == '0)
      return FWD_RF;
    if (mem.valid && mem.dst == src)
      return FWD_MEM;
    if (wb.valid && wb.dst == src)
      return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage fields in, pipeline controls out.
// master = pipeline side, slave = controller.
interface pipeline_hazard_ctrl_if;
  import pipeline_pkg::*;

  logic [OP_W-1:0] op_id;
  logic [RA_W-1:0] rs_id;
  logic [RA_W-1:0] rt_id;
  logic [RA_W-1:0] rd_id;
  logic            stall;
  logic            stall_pm;
  logic            flush;
  logic            halted;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;

  modport master (
    output op_id, rs_id, rt_id, rd_id,
    input  stall, stall_pm, flush, halted,
    input  fwd_a, fwd_b
  );

  modport slave (
    input  op_id, rs_id, rt_id, rd_id,
    output stall, stall_pm, flush, halted,
    output fwd_a, fwd_b
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_decode.sv
// Opcode to class / register-usage decoder.
// Unlisted opcodes fall through as NOP.
module op_class_decode
  import pipeline_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output op_info_t        info
);

  // Classify the opcode and flag which fields it uses.
  always_comb begin
    info.cls     = CLS_NOP;
    info.reads_a = 1'b0;
    info.reads_b = 1'b0;
    info.writes  = 1'b0;
    info.dst_sel = DST_RD;
    unique case (1'b1)
      (op == OP_LOAD): begin
        info.cls     = CLS_LOAD;
        info.reads_a = 1'b1;
        info.writes  = 1'b1;
        info.dst_sel = DST_RT;
      end
      (op == OP_STORE): begin
        info.cls     = CLS_STORE;
        info.reads_a = 1'b1;
        info.reads_b = 1'b1;
      end
      (op == OP_JUMP): info.cls = CLS_JUMP;
      (op == OP_HALT): info.cls = CLS_HALT;
      (op[5:4] == 2'b00 && op != OP_NOP): begin
        info.cls     = CLS_ALU;
        info.reads_a = 1'b1;
        info.reads_b = 1'b1;
        info.writes  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use stall, jump flush,
// halt freeze and EX forwarding from a 3-deep scoreboard.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  op_info_t  info;
  state_e    state;
  state_e    state_nx;
  logic [1:0] jcnt;
  logic [1:0] jcnt_nx;
  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t wb_q;
  sb_entry_t id_ent;
  logic      load_use;
  logic      stall_w;
  logic      flush_w;
  logic      halted_w;

  op_class_decode u_dec (
    .op   (bus.op_id),
    .info (info)
  );

  // Build the scoreboard entry the ID instruction would occupy.
  always_comb begin
    id_ent         = '0;
    id_ent.is_load = (info.cls == CLS_LOAD);
    id_ent.dst     = (info.dst_sel == DST_RT) ? bus.rt_id : bus.rd_id;
    id_ent.valid   = info.writes && (id_ent.dst != '0);
    id_ent.src_a   = info.reads_a ? bus.rs_id : '0;
    id_ent.src_b   = info.reads_b ? bus.rt_id : '0;
  end

  assign load_use = (state == ST_RUN)
                 && ex_q.valid && ex_q.is_load
                 && (ex_q.dst != '0)
                 && ((info.reads_a && bus.rs_id == ex_q.dst)
                  || (info.reads_b && bus.rt_id == ex_q.dst));

  // State and jump-countdown register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      jcnt  <= 2'd0;
    end else begin
      state <= state_nx;
      jcnt  <= jcnt_nx;
    end
  end

  // Next state: a stalled jump/halt waits for the stall to clear.
  always_comb begin
    state_nx = state;
    jcnt_nx  = jcnt;
    unique case (state)
      ST_RUN: begin
        if (!load_use) begin
          if (info.cls == CLS_JUMP) begin
            state_nx = ST_JWAIT;
            jcnt_nx  = 2'd2;
          end else if (info.cls == CLS_HALT) begin
            state_nx = ST_HALT;
          end
        end
      end
      ST_JWAIT: begin
        jcnt_nx = jcnt - 2'd1;
        if (jcnt == 2'd1)
          state_nx = ST_RUN;
      end
      ST_HALT: ;
      default: state_nx = ST_RUN;
    endcase
  end

  // Per-state pipeline controls.
  always_comb begin
    stall_w  = 1'b0;
    flush_w  = 1'b0;
    halted_w = 1'b0;
    unique case (state)
      ST_RUN:   stall_w = load_use;
      ST_JWAIT: flush_w = 1'b1;
      ST_HALT: begin
        stall_w  = 1'b1;
        halted_w = 1'b1;
      end
      default: ;
    endcase
  end

  // Scoreboard shift; stalled or flushed slots become bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= (stall_w || flush_w) ? '0 : id_ent;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign bus.stall    = stall_w;
  assign bus.stall_pm = stall_w;
  assign bus.flush    = flush_w;
  assign bus.halted   = halted_w;
  assign bus.fwd_a    = fwd_sel(ex_q.src_a, mem_q, wb_q);
  assign bus.fwd_b    = fwd_sel(ex_q.src_b, mem_q, wb_q);

  logic unused_bits;
  assign unused_bits = ^{mem_q.is_load, mem_q.src_a,
                         mem_q.src_b, wb_q.is_load,
                         wb_q.src_a, wb_q.src_b};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus
// random traffic against an instruction-level model.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  pipeline_hazard_ctrl_if bus();

  pipeline_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] ALU_ADD = 6'b000001;

  typedef struct {
    bit wr;
    bit ld;
    int dst;
    int sa;
    int sb;
  } ent_t;

  ent_t pipe [3];
  int   flush_left;
  bit   m_halted;
  int   checks = 0;
  int   errors = 0;

  logic       o_stall, o_stall_pm, o_flush, o_halted;
  logic [1:0] o_fa, o_fb;

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic ent_t bubble();
    ent_t e;
    e.wr = 0; e.ld = 0; e.dst = 0; e.sa = 0; e.sb = 0;
    return e;
  endfunction

  // Destination / sources straight from the ISA table.
  function automatic ent_t m_decode(input logic [5:0] op,
                                    input int rs, rt, rd);
    ent_t e = bubble();
    if (op == 6'b010100) begin
      e.ld = 1; e.dst = rt; e.sa = rs;
    end else if (op == 6'b010101) begin
      e.sa = rs; e.sb = rt;
    end else if (op[5:4] == 2'b00 && op != 6'b0) begin
      e.dst = rd; e.sa = rs; e.sb = rt;
    end
    e.wr = (e.dst != 0);
    return e;
  endfunction

  function automatic logic [1:0] m_fwd(input int src);
    if (src == 0) return 2'b00;
    if (pipe[1].wr && pipe[1].dst == src) return 2'b01;
    if (pipe[2].wr && pipe[2].dst == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    flush_left = 0;
    m_halted = 0;
    o_stall = 0;
    o_halted = 0;
  endfunction

  // One clock with this instruction in ID; checks every output.
  task automatic cyc(input logic [5:0] op, input int rs, rt, rd);
    ent_t id;
    bit lu, e_st, e_fl;
    bus.op_id = op;
    bus.rs_id = rs[2:0];
    bus.rt_id = rt[2:0];
    bus.rd_id = rd[2:0];
    @(negedge clk);
    o_stall = bus.stall; o_stall_pm = bus.stall_pm;
    o_flush = bus.flush; o_halted = bus.halted;
    o_fa = bus.fwd_a; o_fb = bus.fwd_b;
    id = m_decode(op, rs, rt, rd);
    lu = !m_halted && flush_left == 0
      && pipe[0].ld && pipe[0].wr
      && ((id.sa != 0 && id.sa == pipe[0].dst)
       || (id.sb != 0 && id.sb == pipe[0].dst));
    e_st = lu || m_halted;
    e_fl = flush_left > 0;
    chk("stall", 8'(o_stall), 8'(e_st));
    chk("stall_pm", 8'(o_stall_pm), 8'(e_st));
    chk("flush", 8'(o_flush), 8'(e_fl));
    chk("halted", 8'(o_halted), 8'(m_halted));
    chk("fwd_a", 8'(o_fa), 8'(m_fwd(pipe[0].sa)));
    chk("fwd_b", 8'(o_fb), 8'(m_fwd(pipe[0].sb)));
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (e_st || e_fl) ? bubble() : id;
    if (flush_left > 0)
      flush_left--;
    else if (!m_halted && !lu) begin
      if (op == 6'b011110) flush_left = 2;
      else if (op == 6'b010001) m_halted = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_zero"},
        {bus.stall, bus.stall_pm, bus.flush, bus.halted,
         bus.fwd_a, bus.fwd_b}, 8'h00);
    model_reset();
    bus.op_id = 6'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [5:0] r_op;
  int r_rs, r_rt, r_rd;
  int halt_cnt;

  initial begin
    bus.op_id = 0; bus.rs_id = 0; bus.rt_id = 0; bus.rd_id = 0;
    model_reset();
    #2;
    apply_reset("init");

    // Load-use: LOAD r2<-[r1]; ALU r3 = r2 + r4
    cyc(OP_LOAD, 1, 2, 0);
    cyc(ALU_ADD, 2, 4, 3);
    chk("lu_stall", 8'(o_stall), 8'd1);
    chk("lu_stall_pm", 8'(o_stall_pm), 8'd1);
    cyc(ALU_ADD, 2, 4, 3);
    chk("lu_one_cycle", 8'(o_stall), 8'd0);
    cyc(OP_NOP, 0, 0, 0);
    chk("lu_fwd_wb", 8'(o_fa), 8'd2);

    // Back-to-back ALU forwarding from MEM
    cyc(ALU_ADD, 1, 1, 2);
    cyc(ALU_ADD, 2, 2, 5);
    cyc(OP_NOP, 0, 0, 0);
    chk("fwd_mem_ab", {o_fa, o_fb}, 8'h05);
    // One NOP apart: forward from WB
    cyc(ALU_ADD, 1, 1, 2);
    cyc(OP_NOP, 0, 0, 0);
    cyc(ALU_ADD, 2, 2, 5);
    cyc(OP_NOP, 0, 0, 0);
    chk("fwd_wb_ab", {o_fa, o_fb}, 8'h0a);
    // r0 destination never forwards
    cyc(ALU_ADD, 1, 1, 0);
    cyc(ALU_ADD, 0, 0, 5);
    cyc(OP_NOP, 0, 0, 0);
    chk("fwd_r0", {o_fa, o_fb}, 8'h00);

    // Jump with a HALT arriving during JWAIT
    cyc(OP_JUMP, 0, 0, 0);
    chk("jmp_n_flush", 8'(o_flush), 8'd0);
    cyc(OP_HALT, 0, 0, 0);
    chk("jmp_n1", {o_flush, o_stall}, 8'h2);
    cyc(OP_HALT, 0, 0, 0);
    chk("jmp_n2", {o_flush, o_stall, o_halted}, 8'h4);
    cyc(OP_NOP, 0, 0, 0);
    chk("jmp_n3_run", {o_flush, o_stall}, 8'h0);
    cyc(OP_NOP, 0, 0, 0);
    chk("jmp_halt_ignored", 8'(o_halted), 8'd0);

    // Priority: independent LOAD then JUMP
    cyc(OP_LOAD, 0, 1, 0);
    cyc(OP_JUMP, 0, 0, 0);
    chk("ld_jmp_nostall", {o_stall, o_flush}, 8'h0);
    cyc(OP_NOP, 0, 0, 0);
    chk("ld_jmp_flush", 8'(o_flush), 8'd1);
    cyc(OP_NOP, 0, 0, 0);
    cyc(OP_NOP, 0, 0, 0);
    // LOAD r1 then STORE using r1
    cyc(OP_LOAD, 0, 1, 0);
    cyc(OP_STORE, 1, 3, 0);
    chk("ld_st_stall", 8'(o_stall), 8'd1);
    cyc(OP_STORE, 1, 3, 0);
    chk("ld_st_release", 8'(o_stall), 8'd0);

    // Reset in the middle of JWAIT
    cyc(OP_JUMP, 0, 0, 0);
    cyc(OP_NOP, 0, 0, 0);
    chk("jwait_flush", 8'(o_flush), 8'd1);
    apply_reset("rst_jwait");
    for (int i = 0; i < 3; i++) begin
      cyc(ALU_ADD, i + 1, i + 2, i + 3);
      chk("post_rst_run", {o_stall, o_flush}, 8'h0);
    end

    // Halt held for many cycles, whatever arrives in ID
    cyc(OP_HALT, 0, 0, 0);
    chk("halt_n", 8'(o_halted), 8'd0);
    for (int i = 0; i < 22; i++) begin
      cyc(6'($urandom), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 7));
      chk("halt_hold", {o_stall, o_stall_pm, o_halted}, 8'h7);
    end
    apply_reset("rst_halt");
    for (int i = 0; i < 3; i++) begin
      cyc(ALU_ADD, 1, 2, 3);
      chk("post_halt_run", {o_stall, o_halted}, 8'h0);
    end

    // Random traffic; a stalled ID instruction is held
    halt_cnt = 0;
    r_op = 0; r_rs = 0; r_rt = 0; r_rd = 0;
    for (int i = 0; i < 3000; i++) begin
      halt_cnt = m_halted ? halt_cnt + 1 : 0;
      if (halt_cnt > 4 || $urandom_range(0, 199) == 0) begin
        apply_reset("rand_rst");
        halt_cnt = 0;
        continue;
      end
      if (!(o_stall && !o_halted)) begin
        case ($urandom_range(0, 11))
          0, 1:    r_op = OP_NOP;
          2, 3, 4: r_op = {2'b00, 4'($urandom_range(1, 15))};
          5, 6:    r_op = OP_LOAD;
          7:       r_op = OP_STORE;
          8:       r_op = OP_JUMP;
          9:       r_op = ($urandom_range(0, 3) == 0)
                        ? OP_HALT : OP_NOP;
          default: r_op = 6'($urandom);
        endcase
        r_rs = $urandom_range(0, 3);
        r_rt = $urandom_range(0, 3);
        r_rd = $urandom_range(0, 7);
      end
      cyc(r_op, r_rs, r_rt, r_rd);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
